// File: rtl/lambda_pkg.sv
// Shared definitions for the lambda-calculus front end: token kinds, the
// token record passed from lexer to parser, and ASCII character classes.
package lambda_pkg;

    localparam logic [2:0] TK_ERR    = 3'd0;
    localparam logic [2:0] TK_LAMBDA = 3'd1;
    localparam logic [2:0] TK_DOT    = 3'd2;
    localparam logic [2:0] TK_LPAREN = 3'd3;
    localparam logic [2:0] TK_RPAREN = 3'd4;
    localparam logic [2:0] TK_EQUALS = 3'd5;
    localparam logic [2:0] TK_IDENT  = 3'd6;
    localparam logic [2:0] TK_EOF    = 3'd7;

    // Widest identifier ID any consumer may configure; narrower users truncate.
    localparam int TOK_ID_MAX_W = 8;

    typedef struct packed {
        logic [2:0]              kind;
        logic [TOK_ID_MAX_W-1:0] id;
    } tok_t;

    localparam logic [7:0] CH_TAB    = 8'd9;
    localparam logic [7:0] CH_LF     = 8'd10;
    localparam logic [7:0] CH_CR     = 8'd13;
    localparam logic [7:0] CH_SPACE  = 8'd32;
    localparam logic [7:0] CH_BSLASH = 8'h5C;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_LPAREN = 8'h28;
    localparam logic [7:0] CH_RPAREN = 8'h29;
    localparam logic [7:0] CH_EQUALS = 8'h3D;
    localparam logic [7:0] CH_A      = 8'h61;
    localparam logic [7:0] CH_Z      = 8'h7A;

    typedef enum logic [2:0] {
        CC_IDLE,
        CC_LETTER,
        CC_SPACE,
        CC_PUNCT,
        CC_BAD
    } char_class_t;

    function automatic char_class_t char_class(input logic [7:0] c);
        if (c == 8'd0)
            return CC_IDLE;
        if (c >= CH_A && c <= CH_Z)
            return CC_LETTER;
        if (c == CH_TAB || c == CH_LF || c == CH_CR || c == CH_SPACE)
            return CC_SPACE;
        if (c == CH_BSLASH || c == CH_DOT || c == CH_LPAREN ||
            c == CH_RPAREN || c == CH_EQUALS)
            return CC_PUNCT;
        return CC_BAD;
    endfunction

    // Kind of a single-byte token; anything that is not punctuation is ERR.
    function automatic logic [2:0] punct_kind(input logic [7:0] c);
        case (c)
            CH_BSLASH: return TK_LAMBDA;
            CH_DOT:    return TK_DOT;
            CH_LPAREN: return TK_LPAREN;
            CH_RPAREN: return TK_RPAREN;
            CH_EQUALS: return TK_EQUALS;
            default:   return TK_ERR;
        endcase
    endfunction

endpackage

// File: rtl/lambda_tok_fifo.sv
// Token FIFO: two in-order write ports (port 0 has priority), one read port,
// count-based full/empty. A same-cycle pop frees a slot for the writes.
module lambda_tok_fifo
    import lambda_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_25mhz,
    input  logic reset,
    input  logic wr0_en,
    input  tok_t wr0_tok,
    input  logic wr1_en,
    input  tok_t wr1_tok,
    input  logic rd_en,
    output logic rd_valid,
    output tok_t rd_tok,
    output logic drop
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (1 << PW) != DEPTH) begin : g_bad_depth
        $error("lambda_tok_fifo: DEPTH must be a power of two, at least 2");
    end

    tok_t          mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, space;
    logic          pop, acc0, acc1;
    logic [1:0]    n_wr;

    // Admission: earliest tokens take the free slots, later ones are dropped
    always_comb begin
        pop   = rd_en && (count != '0);
        space = CW'(DEPTH) - count + CW'(pop);
        acc0  = wr0_en && (space != '0);
        acc1  = wr1_en && (space > CW'(acc0));
        n_wr  = 2'(acc0) + 2'(acc1);
        drop  = (wr0_en && !acc0) || (wr1_en && !acc1);
    end

    // Token storage, written in arrival order
    always_ff @(posedge clk_25mhz) begin
        if (acc0)
            mem[wr_ptr] <= wr0_tok;
        if (acc1)
            mem[wr_ptr + PW'(acc0)] <= wr1_tok;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_25mhz) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(n_wr);
            count  <= count + CW'(n_wr) - CW'(pop);
        end
    end

    assign rd_valid = (count != '0);
    assign rd_tok   = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/lambda_lexer.sv
// Byte-serial lexer feeding the lambda-calculus parser. Identifiers are
// reduced to small IDs; tokens leave through a 2-write/1-read FIFO.
// Build option LAMBDA_LEXER_SYMTAB_EN: intern identifiers in a symbol table.
// Without it, tok_id is a letter-sum hash (sum of char-'a'+1 mod 2**ID_W);
// distinct names may collide and the table-full error never occurs.
module lambda_lexer
    import lambda_pkg::*;
#(
    parameter int MAX_LEN    = 4,
    parameter int NSYM       = 8,
    parameter int ID_W       = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk_25mhz,
    input  logic            reset,
    input  logic [7:0]      data_in,
    output logic            tok_valid,
    input  logic            tok_ready,
    output logic [2:0]      tok_kind,
    output logic [ID_W-1:0] tok_id,
    output logic            err,
    output logic            overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IDENT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam int         LW       = $clog2(MAX_LEN + 1);

    if ((1 << ID_W) < NSYM) begin : g_bad_id_w
        $error("lambda_lexer: ID_W too narrow for NSYM");
    end

    logic [1:0]    state, nxt_state;
    logic          prev_nz;
    logic [LW-1:0] acc_len;
    char_class_t   cls;
    tok_t          byte_tok, eof_tok, ident_tok, wr0_tok, wr1_tok, head_tok;
    logic          wr0_en, wr1_en, start, append, trunc, finish;
    logic          ident_bad, fifo_drop;
    logic          unused_id_hi;

    // Classify the byte and decide which tokens to enqueue this cycle
    always_comb begin
        cls           = char_class(data_in);
        byte_tok      = '0;
        byte_tok.kind = punct_kind(data_in);
        if (cls == CC_BAD)
            byte_tok.id = TOK_ID_MAX_W'(data_in[ID_W-1:0]);
        eof_tok      = '0;
        eof_tok.kind = TK_EOF;
        nxt_state = state;
        wr0_en    = 1'b0;
        wr1_en    = 1'b0;
        wr0_tok   = '0;
        wr1_tok   = '0;
        start     = 1'b0;
        append    = 1'b0;
        trunc     = 1'b0;
        finish    = 1'b0;
        if (state == ST_IDENT) begin
            if (cls == CC_LETTER) begin
                if (acc_len == LW'(MAX_LEN))
                    trunc = 1'b1;
                else
                    append = 1'b1;
            end else begin
                // Identifier goes first, its terminator right behind it
                finish  = 1'b1;
                wr0_en  = 1'b1;
                wr0_tok = ident_tok;
                if (cls == CC_PUNCT || cls == CC_BAD) begin
                    wr1_en  = 1'b1;
                    wr1_tok = byte_tok;
                end else if (cls == CC_IDLE) begin
                    wr1_en  = 1'b1;
                    wr1_tok = eof_tok;
                end
                nxt_state = (cls == CC_IDLE) ? ST_DONE : ST_IDLE;
            end
        end else begin
            case (cls)
                CC_LETTER: begin
                    start     = 1'b1;
                    nxt_state = ST_IDENT;
                end
                CC_PUNCT, CC_BAD: begin
                    wr0_en    = 1'b1;
                    wr0_tok   = byte_tok;
                    nxt_state = ST_IDLE;
                end
                CC_SPACE: nxt_state = ST_IDLE;
                default: begin
                    // End of a burst: one EOF after the last nonzero byte
                    if (prev_nz) begin
                        wr0_en    = 1'b1;
                        wr0_tok   = eof_tok;
                        nxt_state = ST_DONE;
                    end
                end
            endcase
        end
    end

    // Identifier length; characters beyond MAX_LEN are not counted
    always_ff @(posedge clk_25mhz) begin
        if (start)
            acc_len <= LW'(1);
        else if (append)
            acc_len <= acc_len + LW'(1);
    end

`ifdef LAMBDA_LEXER_SYMTAB_EN
    localparam int SW = ID_W + 1;
    localparam int AW = MAX_LEN * 8;

    logic [AW-1:0]   acc_chr;
    logic [AW-1:0]   sym_chr [NSYM];
    logic [LW-1:0]   sym_len [NSYM];
    logic [NSYM-1:0] sym_vld;
    logic [SW-1:0]   sym_cnt;
    logic            hit, tab_full, alloc;
    logic [ID_W-1:0] hit_idx;

    // Name accumulator; unused tail stays zero so whole-vector compares work
    always_ff @(posedge clk_25mhz) begin
        if (start)
            acc_chr <= AW'(data_in);
        for (int k = 0; k < MAX_LEN; k++) begin
            if (append && acc_len == LW'(k))
                acc_chr[k*8 +: 8] <= data_in;
        end
    end

    // Parallel lookup against every valid entry, then hit/allocate/full
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (!hit && sym_vld[i] && sym_len[i] == acc_len && sym_chr[i] == acc_chr) begin
                hit     = 1'b1;
                hit_idx = ID_W'(i);
            end
        end
        tab_full  = (sym_cnt == SW'(NSYM));
        ident_bad = !hit && tab_full;
        alloc     = finish && !hit && !tab_full;
        ident_tok = '0;
        if (hit) begin
            ident_tok.kind = TK_IDENT;
            ident_tok.id   = TOK_ID_MAX_W'(hit_idx);
        end else if (!tab_full) begin
            ident_tok.kind = TK_IDENT;
            ident_tok.id   = TOK_ID_MAX_W'(sym_cnt[ID_W-1:0]);
        end else begin
            ident_tok.kind = TK_ERR;
        end
    end

    // Entry occupancy and next free index
    always_ff @(posedge clk_25mhz) begin
        if (!reset) begin
            sym_vld <= '0;
            sym_cnt <= '0;
        end else if (alloc) begin
            sym_vld[sym_cnt[ID_W-1:0]] <= 1'b1;
            sym_cnt                    <= sym_cnt + SW'(1);
        end
    end

    // Entry contents, captured when a new name is interned
    always_ff @(posedge clk_25mhz) begin
        if (alloc) begin
            sym_chr[sym_cnt[ID_W-1:0]] <= acc_chr;
            sym_len[sym_cnt[ID_W-1:0]] <= acc_len;
        end
    end
`else
    logic [ID_W-1:0] acc_sum, letter_val;

    assign letter_val = ID_W'(data_in - 8'd96);

    // Running letter-sum hash of the stored characters
    always_ff @(posedge clk_25mhz) begin
        if (start)
            acc_sum <= letter_val;
        else if (append)
            acc_sum <= acc_sum + letter_val;
    end

    // Hash mode never runs out of IDs
    always_comb begin
        ident_tok      = '0;
        ident_tok.kind = TK_IDENT;
        ident_tok.id   = TOK_ID_MAX_W'(acc_sum);
        ident_bad      = 1'b0;
    end
`endif

    // Lexer state, previous-byte tracker and sticky flags
    always_ff @(posedge clk_25mhz) begin
        if (!reset) begin
            state    <= ST_IDLE;
            prev_nz  <= 1'b0;
            err      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state   <= nxt_state;
            prev_nz <= (data_in != 8'd0);
            if (cls == CC_BAD || trunc || (finish && ident_bad))
                err <= 1'b1;
            if (fifo_drop)
                overflow <= 1'b1;
        end
    end

    lambda_tok_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .wr0_en    (wr0_en),
        .wr0_tok   (wr0_tok),
        .wr1_en    (wr1_en),
        .wr1_tok   (wr1_tok),
        .rd_en     (tok_ready),
        .rd_valid  (tok_valid),
        .rd_tok    (head_tok),
        .drop      (fifo_drop)
    );

    assign tok_kind     = head_tok.kind;
    assign tok_id       = head_tok.id[ID_W-1:0];
    assign unused_id_hi = ^head_tok.id;

endmodule

// File: tb/tb_lambda_lexer.sv
// Scoreboard bench for lambda_lexer: directed character streams push their
// hand-computed tokens into a queue; a monitor pops on every handshake.
`timescale 1ns/1ps
module tb_lambda_lexer;
    import lambda_pkg::*;

    localparam int ID_W = 3;
`ifdef LAMBDA_LEXER_SYMTAB_EN
    localparam bit SYMTAB = 1'b1;
`else
    localparam bit SYMTAB = 1'b0;
`endif

    logic            clk_25mhz = 1'b0;
    logic            reset     = 1'b0;
    logic [7:0]      data_in   = 8'd0;
    logic            tok_ready = 1'b1;
    logic            tok_valid, err, overflow;
    logic [2:0]      tok_kind;
    logic [ID_W-1:0] tok_id;

    lambda_lexer #(
        .MAX_LEN    (4),
        .NSYM       (8),
        .ID_W       (ID_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .data_in   (data_in),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_kind  (tok_kind),
        .tok_id    (tok_id),
        .err       (err),
        .overflow  (overflow)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    typedef struct packed {
        logic [2:0]      kind;
        logic [ID_W-1:0] id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_tok = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic void ex(input logic [2:0] k, input int id);
        exp_t e;
        e.kind = k;
        e.id   = id[ID_W-1:0];
        sb.push_back(e);
    endfunction

    // Monitor: inputs change on negedge, so #1 later everything is settled
    always @(negedge clk_25mhz) begin
        #1;
        if (tok_valid && tok_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_tok%0d: got kind %0d id %0d, want no token",
                         n_tok, tok_kind, tok_id);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("tok%0d_kind", n_tok), int'(tok_kind), int'(mon_e.kind));
                check($sformatf("tok%0d_id", n_tok), int'(tok_id), int'(mon_e.id));
            end
            n_tok++;
        end
    end

    task automatic send(input logic [7:0] b);
        data_in = b;
        @(negedge clk_25mhz);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send(s[i]);
    endtask

    task automatic do_reset();
        data_in   = 8'd0;
        tok_ready = 1'b1;
        reset     = 1'b0;
        @(negedge clk_25mhz);
        reset = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++)
            @(negedge clk_25mhz);
        check({name, "_drained_left"}, sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk_25mhz);
        check({name, "_valid_after"}, int'(tok_valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_25mhz);
        @(negedge clk_25mhz);
        check("rst_valid", int'(tok_valid), 0);
        check("rst_kind", int'(tok_kind), 0);
        check("rst_id", int'(tok_id), 0);
        check("rst_err", int'(err), 0);
        check("rst_ovf", int'(overflow), 0);
        reset = 1'b1;
        @(negedge clk_25mhz);

        // Simple definition
        ex(TK_IDENT, SYMTAB ? 0 : 5);
        ex(TK_EQUALS, 0);
        ex(TK_LAMBDA, 0);
        ex(TK_IDENT, SYMTAB ? 1 : 0);
        ex(TK_DOT, 0);
        ex(TK_IDENT, SYMTAB ? 1 : 0);
        ex(TK_EOF, 0);
        send_str(" id=\\x.x");
        send(8'd0);
        drain("t1");
        check("t1_err", int'(err), 0);

        // Parenthesised abstraction with multi-letter names
        do_reset();
        ex(TK_LPAREN, 0);
        ex(TK_LAMBDA, 0);
        ex(TK_IDENT, 0);
        ex(TK_DOT, 0);
        ex(TK_IDENT, 0);
        ex(TK_RPAREN, 0);
        ex(TK_IDENT, SYMTAB ? 1 : 3);
        ex(TK_EOF, 0);
        send_str("    (\\xxx.xxx) yyy");
        send(8'd0);
        drain("t2");
        check("t2_ovf", int'(overflow), 0);
        check("t2_err", int'(err), 0);

        // Back-pressure: five pushes into four slots
        do_reset();
        tok_ready = 1'b0;
        send_str("(((((");
        send(8'd0);
        repeat (2) @(negedge clk_25mhz);
        check("t3_valid", int'(tok_valid), 1);
        check("t3_ovf", int'(overflow), 1);
        check("t3_hold_kind0", int'(tok_kind), int'(TK_LPAREN));
        repeat (3) @(negedge clk_25mhz);
        check("t3_hold_kind1", int'(tok_kind), int'(TK_LPAREN));
        check("t3_hold_id", int'(tok_id), 0);
        repeat (4) ex(TK_LPAREN, 0);
        tok_ready = 1'b1;
        drain("t3");
        check("t3_ovf_sticky", int'(overflow), 1);

        // Double write with one free slot: IDENT kept, RPAREN dropped
        do_reset();
        tok_ready = 1'b0;
        send_str("((( ab)");
        send(8'd0);
        repeat (2) @(negedge clk_25mhz);
        check("t3b_ovf", int'(overflow), 1);
        repeat (3) ex(TK_LPAREN, 0);
        ex(TK_IDENT, SYMTAB ? 0 : 3);
        tok_ready = 1'b1;
        drain("t3b");

        // Over-long name truncates to MAX_LEN characters
        do_reset();
        ex(TK_IDENT, SYMTAB ? 0 : 2);
        ex(TK_DOT, 0);
        ex(TK_IDENT, SYMTAB ? 0 : 2);
        ex(TK_EOF, 0);
        send_str("abcdef.");
        send_str("abcd");
        send(8'd0);
        drain("t4");
        check("t4_err", int'(err), 1);

        // Bad character terminates an identifier
        do_reset();
        ex(TK_IDENT, 0);
        ex(TK_ERR, 3);
        ex(TK_EOF, 0);
        send_str("x#");
        send(8'd0);
        drain("t5");
        check("t5_err", int'(err), 1);

        // Nine distinct single-letter names
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (SYMTAB)
                ex((i < 8) ? TK_IDENT : TK_ERR, (i < 8) ? i : 0);
            else
                ex(TK_IDENT, (i + 1) % 8);
            send(8'h61 + 8'(i));
            send((i == 8) ? 8'd0 : 8'd32);
        end
        ex(TK_EOF, 0);
        drain("t5b");
        check("t5b_err", int'(err), SYMTAB ? 1 : 0);

        // Reset in the middle of an identifier
        do_reset();
        ex(TK_ERR, 3);
        send(8'h23);
        send_str("xy");
        reset   = 1'b0;
        data_in = 8'd0;
        @(negedge clk_25mhz);
        reset = 1'b1;
        check("t6_rst_valid", int'(tok_valid), 0);
        check("t6_rst_err", int'(err), 0);
        check("t6_rst_ovf", int'(overflow), 0);
        check("t6_pending", sb.size(), 0);
        sb.delete();
        ex(TK_IDENT, SYMTAB ? 0 : 2);
        ex(TK_DOT, 0);
        ex(TK_EOF, 0);
        send_str("z.");
        send(8'd0);
        drain("t6");
        check("t6_err", int'(err), 0);
        check("t6_ovf", int'(overflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
